// File: rtl/alu_issue_queue_if.sv
// Bundle between dispatch/wake/ALU and the ALU issue queue.
// The queue attaches through the slave modport; its environment uses master.
interface alu_issue_queue_if #(
    parameter int DEPTH     = 8,
    parameter int TAG_W     = 6,
    parameter int PAYLOAD_W = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                 flush;
    logic                 Stall;

    logic                 In1_valid,    In2_valid;
    logic [TAG_W-1:0]     In1_Src1,     In1_Src2,     In2_Src1,     In2_Src2;
    logic                 In1_Src1_Rdy, In1_Src2_Rdy, In2_Src1_Rdy, In2_Src2_Rdy;
    logic [TAG_W-1:0]     In1_Phydst,   In2_Phydst;
    logic [PAYLOAD_W-1:0] In1_Payload,  In2_Payload;

    logic                 ALU0_wake,   ALU1_wake,   BU_wake,   DU_wake;
    logic [TAG_W-1:0]     ALU0_Phydst, ALU1_Phydst, BU_Phydst, DU_Phydst;

    logic                 Full;
    logic [CNT_W-1:0]     Count;

    logic                 Issue_valid;
    logic                 Issue_ready;
    logic [TAG_W-1:0]     Issue_Src1, Issue_Src2, Issue_Phydst;
    logic [PAYLOAD_W-1:0] Issue_Payload;

    modport master (
        output flush, Stall,
               In1_valid, In2_valid,
               In1_Src1, In1_Src2, In2_Src1, In2_Src2,
               In1_Src1_Rdy, In1_Src2_Rdy, In2_Src1_Rdy, In2_Src2_Rdy,
               In1_Phydst, In2_Phydst, In1_Payload, In2_Payload,
               ALU0_wake, ALU1_wake, BU_wake, DU_wake,
               ALU0_Phydst, ALU1_Phydst, BU_Phydst, DU_Phydst,
               Issue_ready,
        input  Full, Count,
               Issue_valid, Issue_Src1, Issue_Src2, Issue_Phydst, Issue_Payload
    );

    modport slave (
        input  flush, Stall,
               In1_valid, In2_valid,
               In1_Src1, In1_Src2, In2_Src1, In2_Src2,
               In1_Src1_Rdy, In1_Src2_Rdy, In2_Src1_Rdy, In2_Src2_Rdy,
               In1_Phydst, In2_Phydst, In1_Payload, In2_Payload,
               ALU0_wake, ALU1_wake, BU_wake, DU_wake,
               ALU0_Phydst, ALU1_Phydst, BU_Phydst, DU_Phydst,
               Issue_ready,
        output Full, Count,
               Issue_valid, Issue_Src1, Issue_Src2, Issue_Phydst, Issue_Payload
    );
endinterface

// File: rtl/alu_issue_queue.sv
// Compacting, age-ordered issue queue for one ALU pipe: index 0 is the oldest
// entry, the oldest fully-ready entry is offered to the ALU every cycle.
module alu_issue_queue #(
    parameter int DEPTH     = 8,
    parameter int TAG_W     = 6,
    parameter int PAYLOAD_W = 32
) (
    input logic               clk,
    input logic               rst,
    alu_issue_queue_if.slave  q
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic                 valid;
        logic [TAG_W-1:0]     src1;
        logic [TAG_W-1:0]     src2;
        logic                 rdy1;
        logic                 rdy2;
        logic [TAG_W-1:0]     phydst;
        logic [PAYLOAD_W-1:0] payload;
    } entry_t;

    entry_t           entry_q [DEPTH];
    entry_t           entry_d [DEPTH];
    entry_t           ext     [DEPTH+1];
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q,  full_d;

    logic [3:0]         wake_v;
    logic [4*TAG_W-1:0] wake_tags;

    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    entry_t           sel_entry;
    logic             issue_valid;
    logic             do_issue;
    logic             accept1, accept2;
    logic [CNT_W-1:0] count_after, slot1, slot2;
    entry_t           new1, new2, cur;

    assign wake_v    = {q.DU_wake, q.BU_wake, q.ALU1_wake, q.ALU0_wake};
    assign wake_tags = {q.DU_Phydst, q.BU_Phydst, q.ALU1_Phydst, q.ALU0_Phydst};

    function automatic logic wake_hit(input logic [TAG_W-1:0]   tag,
                                      input logic [3:0]         v,
                                      input logic [4*TAG_W-1:0] tags);
        logic hit;
        hit = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (v[b] && (tags[b*TAG_W +: TAG_W] == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

    // Oldest-first select; scanning downward leaves the lowest ready index.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (entry_q[i].valid && entry_q[i].rdy1 && entry_q[i].rdy2) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
        sel_entry   = entry_q[sel_idx];
        issue_valid = sel_found && !q.flush;
    end

    assign q.Issue_valid   = issue_valid;
    assign q.Issue_Src1    = issue_valid ? sel_entry.src1    : '0;
    assign q.Issue_Src2    = issue_valid ? sel_entry.src2    : '0;
    assign q.Issue_Phydst  = issue_valid ? sel_entry.phydst  : '0;
    assign q.Issue_Payload = issue_valid ? sel_entry.payload : '0;
    assign q.Count         = count_q;
    assign q.Full          = full_q;

    always_comb begin
        do_issue = issue_valid && q.Issue_ready;
        accept1  = q.In1_valid && !q.Stall && !full_q && !q.flush && !rst;
        accept2  = q.In2_valid && !q.Stall && !full_q && !q.flush && !rst;

        for (int i = 0; i < DEPTH; i++) ext[i] = entry_q[i];
        ext[DEPTH] = '0;

        // Close the gap left by the issued entry, then apply this edge's wakeups.
        for (int i = 0; i < DEPTH; i++) begin
            if (do_issue && (IDX_W'(i) >= sel_idx)) cur = ext[i+1];
            else                                    cur = ext[i];
            if (cur.valid) begin
                cur.rdy1 = cur.rdy1 | wake_hit(cur.src1, wake_v, wake_tags);
                cur.rdy2 = cur.rdy2 | wake_hit(cur.src2, wake_v, wake_tags);
            end
            entry_d[i] = cur;
        end

        new1.valid   = 1'b1;
        new1.src1    = q.In1_Src1;
        new1.src2    = q.In1_Src2;
        new1.rdy1    = q.In1_Src1_Rdy || (q.In1_Src1 == '0) || wake_hit(q.In1_Src1, wake_v, wake_tags);
        new1.rdy2    = q.In1_Src2_Rdy || (q.In1_Src2 == '0) || wake_hit(q.In1_Src2, wake_v, wake_tags);
        new1.phydst  = q.In1_Phydst;
        new1.payload = q.In1_Payload;

        new2.valid   = 1'b1;
        new2.src1    = q.In2_Src1;
        new2.src2    = q.In2_Src2;
        new2.rdy1    = q.In2_Src1_Rdy || (q.In2_Src1 == '0) || wake_hit(q.In2_Src1, wake_v, wake_tags);
        new2.rdy2    = q.In2_Src2_Rdy || (q.In2_Src2 == '0) || wake_hit(q.In2_Src2, wake_v, wake_tags);
        new2.phydst  = q.In2_Phydst;
        new2.payload = q.In2_Payload;

        // Appends land behind the post-issue tail, In1 ahead of In2.
        count_after = count_q - CNT_W'(do_issue);
        slot1       = count_after;
        slot2       = count_after + CNT_W'(accept1);
        for (int i = 0; i < DEPTH; i++) begin
            if (accept1 && (CNT_W'(i) == slot1)) entry_d[i] = new1;
            if (accept2 && (CNT_W'(i) == slot2)) entry_d[i] = new2;
        end
        count_d = count_after + CNT_W'(accept1) + CNT_W'(accept2);

        if (q.flush) begin
            for (int i = 0; i < DEPTH; i++) entry_d[i] = '0;
            count_d = '0;
        end
        full_d = (count_d > CNT_W'(DEPTH-2));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
            count_q <= count_d;
            full_q  <= full_d;
        end
    end
endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: reset, bypass, wakeup, age order,
// stall/Full boundaries and flush, each checked against hand-computed values.
module tb_alu_issue_queue;
    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    alu_issue_queue_if #(.DEPTH(8), .TAG_W(6), .PAYLOAD_W(32)) bus ();

    alu_issue_queue #(.DEPTH(8), .TAG_W(6), .PAYLOAD_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .q   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        bus.flush = 0; bus.Stall = 0; bus.Issue_ready = 0;
        bus.In1_valid = 0; bus.In1_Src1 = 0; bus.In1_Src2 = 0;
        bus.In1_Src1_Rdy = 0; bus.In1_Src2_Rdy = 0; bus.In1_Phydst = 0; bus.In1_Payload = 0;
        bus.In2_valid = 0; bus.In2_Src1 = 0; bus.In2_Src2 = 0;
        bus.In2_Src1_Rdy = 0; bus.In2_Src2_Rdy = 0; bus.In2_Phydst = 0; bus.In2_Payload = 0;
        bus.ALU0_wake = 0; bus.ALU1_wake = 0; bus.BU_wake = 0; bus.DU_wake = 0;
        bus.ALU0_Phydst = 0; bus.ALU1_Phydst = 0; bus.BU_Phydst = 0; bus.DU_Phydst = 0;
    endtask

    task automatic put1(input logic [5:0] s1, input logic r1, input logic [5:0] s2,
                        input logic r2, input logic [5:0] pd, input logic [31:0] pl);
        bus.In1_valid = 1; bus.In1_Src1 = s1; bus.In1_Src1_Rdy = r1;
        bus.In1_Src2 = s2; bus.In1_Src2_Rdy = r2; bus.In1_Phydst = pd; bus.In1_Payload = pl;
    endtask

    task automatic put2(input logic [5:0] s1, input logic r1, input logic [5:0] s2,
                        input logic r2, input logic [5:0] pd, input logic [31:0] pl);
        bus.In2_valid = 1; bus.In2_Src1 = s1; bus.In2_Src1_Rdy = r1;
        bus.In2_Src2 = s2; bus.In2_Src2_Rdy = r2; bus.In2_Phydst = pd; bus.In2_Payload = pl;
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        next_cycle();
        next_cycle();
        rst = 0;
        next_cycle();

        // Reset / idle
        check("reset_count", bus.Count, 0);
        check("reset_full", bus.Full, 0);
        check("reset_issue_valid", bus.Issue_valid, 0);
        check("reset_issue_fields", {bus.Issue_Src1, bus.Issue_Src2, bus.Issue_Phydst, bus.Issue_Payload}, 0);

        // Two inserts: In1 waits on tag 5, In2 fully ready
        put1(6'd5, 0, 6'd0, 0, 6'd9, 32'h111);
        put2(6'd3, 1, 6'd4, 1, 6'd10, 32'h222);
        next_cycle();
        clear_inputs();
        check("pair_count", bus.Count, 2);
        check("pair_issue_valid", bus.Issue_valid, 1);
        check("pair_issue_phydst", bus.Issue_Phydst, 10);
        check("pair_issue_src", {bus.Issue_Src1, bus.Issue_Src2}, {6'd3, 6'd4});
        check("pair_issue_payload", bus.Issue_Payload, 32'h222);
        bus.ALU0_wake = 1; bus.ALU0_Phydst = 5; bus.Issue_ready = 1;
        #1;
        check("wake_not_same_cycle", bus.Issue_Phydst, 10);
        next_cycle();
        clear_inputs();
        check("wake_issue_valid", bus.Issue_valid, 1);
        check("wake_issue_phydst", bus.Issue_Phydst, 9);
        check("wake_count", bus.Count, 1);
        bus.Issue_ready = 1;
        next_cycle();
        clear_inputs();
        check("drain1_count", bus.Count, 0);
        check("drain1_issue_valid", bus.Issue_valid, 0);

        // Same-cycle bypass from BU plus a mismatched wake
        put1(6'd7, 0, 6'd8, 1, 6'd20, 32'h333);
        put2(6'd12, 0, 6'd0, 0, 6'd21, 32'h444);
        bus.BU_wake = 1; bus.BU_Phydst = 7;
        bus.DU_wake = 1; bus.DU_Phydst = 13;
        next_cycle();
        clear_inputs();
        check("bypass_issue_valid", bus.Issue_valid, 1);
        check("bypass_issue_phydst", bus.Issue_Phydst, 20);
        check("bypass_count", bus.Count, 2);
        bus.Issue_ready = 1;
        next_cycle();
        clear_inputs();
        check("unwoken_not_ready", bus.Issue_valid, 0);
        check("unwoken_count", bus.Count, 1);
        bus.DU_wake = 1; bus.DU_Phydst = 12;
        bus.ALU1_wake = 1; bus.ALU1_Phydst = 12;
        #1;
        check("dup_wake_same_cycle", bus.Issue_valid, 0);
        next_cycle();
        clear_inputs();
        check("dup_wake_issue_phydst", bus.Issue_Phydst, 21);
        bus.Issue_ready = 1;
        next_cycle();
        clear_inputs();
        check("drain2_count", bus.Count, 0);

        // Stall drops inserts; a lone In2 takes the first free slot
        bus.Stall = 1;
        put1(6'd0, 1, 6'd0, 1, 6'd15, 32'h555);
        next_cycle();
        clear_inputs();
        check("stall_count", bus.Count, 0);
        put2(6'd0, 1, 6'd0, 1, 6'd22, 32'h666);
        next_cycle();
        clear_inputs();
        check("in2_only_count", bus.Count, 1);
        check("in2_only_phydst", bus.Issue_Phydst, 22);
        bus.Issue_ready = 1;
        next_cycle();
        clear_inputs();
        check("drain3_count", bus.Count, 0);

        // Age order with hold
        put1(6'd0, 1, 6'd0, 1, 6'd1, 32'h1);
        put2(6'd0, 1, 6'd0, 1, 6'd2, 32'h2);
        next_cycle();
        clear_inputs();
        put1(6'd0, 1, 6'd0, 1, 6'd3, 32'h3);
        next_cycle();
        clear_inputs();
        check("age_count3", bus.Count, 3);
        check("age_first", bus.Issue_Phydst, 1);
        next_cycle();
        check("age_hold_phydst", bus.Issue_Phydst, 1);
        check("age_hold_count", bus.Count, 3);
        bus.Issue_ready = 1;
        next_cycle();
        check("age_second", bus.Issue_Phydst, 2);
        check("age_count2", bus.Count, 2);
        next_cycle();
        check("age_third", bus.Issue_Phydst, 3);
        check("age_count1", bus.Count, 1);
        next_cycle();
        clear_inputs();
        check("age_count0", bus.Count, 0);
        check("age_empty_valid", bus.Issue_valid, 0);

        // Full boundary: entries wait on tags 31..37, Phydst 1..7
        put1(6'd31, 0, 6'd0, 0, 6'd1, 32'h10);
        put2(6'd32, 0, 6'd0, 0, 6'd2, 32'h20);
        next_cycle();
        clear_inputs();
        put1(6'd33, 0, 6'd0, 0, 6'd3, 32'h30);
        put2(6'd34, 0, 6'd0, 0, 6'd4, 32'h40);
        next_cycle();
        clear_inputs();
        put1(6'd35, 0, 6'd0, 0, 6'd5, 32'h50);
        put2(6'd36, 0, 6'd0, 0, 6'd6, 32'h60);
        next_cycle();
        clear_inputs();
        check("fill_count6", bus.Count, 6);
        check("fill_full6", bus.Full, 0);
        put1(6'd37, 0, 6'd0, 0, 6'd7, 32'h70);
        next_cycle();
        clear_inputs();
        check("fill_count7", bus.Count, 7);
        check("fill_full7", bus.Full, 1);
        put1(6'd50, 1, 6'd0, 1, 6'd50, 32'h99);
        put2(6'd51, 1, 6'd0, 1, 6'd51, 32'h98);
        bus.ALU0_wake = 1; bus.ALU0_Phydst = 31;
        next_cycle();
        clear_inputs();
        check("full_drop_count", bus.Count, 7);
        check("full_wake_phydst", bus.Issue_Phydst, 1);
        bus.Issue_ready = 1;
        put1(6'd50, 1, 6'd0, 1, 6'd50, 32'h99);
        next_cycle();
        clear_inputs();
        check("full_issue_count", bus.Count, 6);
        check("full_issue_full", bus.Full, 0);
        check("full_issue_nothing_ready", bus.Issue_valid, 0);
        put1(6'd40, 0, 6'd0, 0, 6'd8, 32'h80);
        put2(6'd41, 0, 6'd0, 0, 6'd9, 32'h90);
        next_cycle();
        clear_inputs();
        check("fill_count8", bus.Count, 8);
        check("fill_full8", bus.Full, 1);
        bus.ALU1_wake = 1; bus.ALU1_Phydst = 32;
        next_cycle();
        clear_inputs();
        check("full8_issue_phydst", bus.Issue_Phydst, 2);
        bus.Issue_ready = 1;
        next_cycle();
        clear_inputs();
        check("after_issue_count7", bus.Count, 7);
        check("after_issue_full7", bus.Full, 1);

        // Flush while the ALU is accepting
        bus.DU_wake = 1; bus.DU_Phydst = 33;
        next_cycle();
        clear_inputs();
        check("pre_flush_phydst", bus.Issue_Phydst, 3);
        bus.flush = 1; bus.Issue_ready = 1;
        #1;
        check("flush_issue_valid", bus.Issue_valid, 0);
        check("flush_issue_phydst", bus.Issue_Phydst, 0);
        next_cycle();
        clear_inputs();
        check("flush_count", bus.Count, 0);
        check("flush_full", bus.Full, 0);
        bus.Issue_ready = 1;
        bus.ALU0_wake = 1; bus.ALU0_Phydst = 34;
        bus.BU_wake = 1; bus.BU_Phydst = 40;
        next_cycle();
        clear_inputs();
        check("post_flush_issue_valid", bus.Issue_valid, 0);
        check("post_flush_count", bus.Count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
